// File: rtl/hilo_md_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hilo_md_ctrl_pkg
//   Shared definitions for the HI/LO multiply/divide sequencer:
//   md_op encodings, controller state encoding, default latencies,
//   counter width and a small decode helper.
// ---------------------------------------------------------------------------
package hilo_md_ctrl_pkg;

   // E-stage HI/LO operation codes carried on md_op.
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_RSV6  = 3'd6,
      OP_RSV7  = 3'd7
   } md_op_e;

   // Controller state. Exposed as a debug output of the top.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;
   localparam int CNT_W           = 6;

   // MULT/MULTU/DIV/DIVU occupy codes 0..3; they are the only ops that
   // start a multi-cycle busy window.
   function automatic logic is_arith(input logic [2:0] op);
      return ~op[2];
   endfunction

   // DIV/DIVU have bit 1 set within the arithmetic group.
   function automatic logic is_div(input logic [2:0] op);
      return ~op[2] & op[1];
   endfunction

endpackage : hilo_md_ctrl_pkg

// File: rtl/hilo_md_ctrl_md_arith.sv
// ---------------------------------------------------------------------------
// md_arith
//   Purely combinational multiply/divide datapath.
//   Ports:
//     op_sel  in  2   low bits of md_op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//     src_a   in  32  rs operand (dividend / multiplicand)
//     src_b   in  32  rt operand (divisor / multiplier)
//     res_hi  out 32  HI result (product high half / remainder)
//     res_lo  out 32  LO result (product low half / quotient)
//   Divide by zero yields hi=src_a, lo=all ones for both signednesses.
// ---------------------------------------------------------------------------
module md_arith (
   input  logic [1:0]  op_sel,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic        is_signed;
   logic        is_divide;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] product;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] div_n;
   logic [31:0] div_d;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] quot;
   logic [31:0] rem;

   assign is_signed = ~op_sel[0];
   assign is_divide = op_sel[1];

   // One 64x64 multiplier serves both signednesses: sign- or zero-extend
   // the operands and keep the low 64 bits of the product.
   assign ext_a   = is_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
   assign ext_b   = is_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
   assign product = ext_a * ext_b;

   // One unsigned divider serves both signednesses: signed division runs
   // on magnitudes and the signs are restored afterwards. The overflow case
   // 0x8000_0000 / -1 falls out naturally: magnitude 0x8000_0000 / 1 gives
   // quotient 0x8000_0000 with no sign change and remainder 0.
   assign a_neg = is_signed & src_a[31];
   assign b_neg = is_signed & src_b[31];
   assign mag_a = a_neg ? (32'd0 - src_a) : src_a;
   assign mag_b = b_neg ? (32'd0 - src_b) : src_b;
   assign div_n = mag_a;
   // Forcing a non-zero divisor keeps the divider output defined; the
   // zero case is overridden below anyway.
   assign div_d = (src_b == 32'd0) ? 32'd1 : mag_b;
   assign uq    = div_n / div_d;
   assign ur    = div_n % div_d;
   assign quot  = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
   assign rem   = a_neg ? (32'd0 - ur) : ur;

   always_comb begin
      res_hi = product[63:32];
      res_lo = product[31:0];
      if (is_divide) begin
         if (src_b == 32'd0) begin
            res_hi = src_a;
            res_lo = 32'hFFFF_FFFF;
         end else begin
            res_hi = rem;
            res_lo = quot;
         end
      end
   end

endmodule : md_arith

// File: rtl/hilo_md_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_md_ctrl
//   Multiply/divide sequencer owning the architectural HI/LO pair.
//   Arithmetic ops latch their result immediately into pending registers
//   and commit to HI/LO after a fixed busy window; MTHI/MTLO write at once.
//   Ports:
//     clk       in  1   clock, rising edge
//     reset     in  1   synchronous, active-low
//     start     in  1   E-stage HI/LO op valid this cycle
//     md_op     in  3   operation code (see hilo_md_ctrl_pkg::md_op_e)
//     src_a     in  32  rs value
//     src_b     in  32  rt value
//     flush     in  1   cancels the E-stage op this cycle
//     md_use_D  in  1   D-stage instruction touches HI/LO
//     busy      out 1   operation in flight
//     stall_md  out 1   stall request to hazard unit
//     hi        out 32  architectural HI
//     lo        out 32  architectural LO
//     state_dbg out 1   current controller state
//
//   Handshake: start is a valid with implicit ready = (state == IDLE).
//   A start with flush low is consumed only at a rising edge in IDLE;
//   a start seen while BUSY is dropped, never queued. The hazard unit
//   uses stall_md so that such a start never arrives in practice.
// ---------------------------------------------------------------------------
module hilo_md_ctrl
   import hilo_md_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   input  logic        md_use_D,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output md_state_e   state_dbg
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

   md_state_e        state_q, state_n;
   logic [CNT_W-1:0] cnt_q,   cnt_n;
   logic [31:0]      p_hi_q,  p_hi_n;
   logic [31:0]      p_lo_q,  p_lo_n;
   logic [31:0]      hi_q,    hi_n;
   logic [31:0]      lo_q,    lo_n;

   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic             accept;

   md_arith u_md_arith (
      .op_sel (md_op[1:0]),
      .src_a  (src_a),
      .src_b  (src_b),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   assign accept = start & ~flush;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         p_hi_q  <= p_hi_n;
         p_lo_q  <= p_lo_n;
         hi_q    <= hi_n;
         lo_q    <= lo_n;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      p_hi_n  = p_hi_q;
      p_lo_n  = p_lo_q;
      hi_n    = hi_q;
      lo_n    = lo_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (is_arith(md_op)) begin
                  p_hi_n  = res_hi;
                  p_lo_n  = res_lo;
                  cnt_n   = is_div(md_op) ? DIV_LOAD : MULT_LOAD;
                  state_n = ST_BUSY;
               end else if (md_op == OP_MTHI) begin
                  hi_n = src_a;
               end else if (md_op == OP_MTLO) begin
                  lo_n = src_a;
               end
               // Reserved codes fall through as no-ops.
            end
         end
         ST_BUSY: begin
            cnt_n = cnt_q - 1'b1;
            // Count of 1 is the last busy cycle: commit at this edge so
            // the new HI/LO and busy=0 appear together.
            if (cnt_q == CNT_W'(1)) begin
               hi_n    = p_hi_q;
               lo_n    = p_lo_q;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy      = (state_q == ST_BUSY);
   assign stall_md  = md_use_D & (busy | (accept & is_arith(md_op)));
   assign hi        = hi_q;
   assign lo        = lo_q;
   assign state_dbg = state_q;

endmodule : hilo_md_ctrl

// File: tb/tb_hilo_md_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_md_ctrl
//   Self-checking bench for hilo_md_ctrl: directed sequences followed by
//   randomized traffic, checked cycle by cycle against a behavioural model
//   (64-bit integer arithmetic plus a remaining-cycles count and a queue
//   of expected commits).
// ---------------------------------------------------------------------------
module tb_hilo_md_ctrl;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam int         N_MULT   = 5;
   localparam int         N_DIV    = 10;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        md_use_D;
   logic        busy;
   logic        stall_md;
   logic [31:0] hi;
   logic [31:0] lo;
   hilo_md_ctrl_pkg::md_state_e state_dbg;

   hilo_md_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .md_op     (md_op),
      .src_a     (src_a),
      .src_b     (src_b),
      .flush     (flush),
      .md_use_D  (md_use_D),
      .busy      (busy),
      .stall_md  (stall_md),
      .hi        (hi),
      .lo        (lo),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard / model state ----------------
   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q[$];
   logic [31:0] m_hi   = 32'd0;
   logic [31:0] m_lo   = 32'd0;
   int          m_left = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference results from plain 64-bit integer arithmetic.
   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         OP_MULT:  return 64'(sa * sb);
         OP_MULTU: return ua * ub;
         OP_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         OP_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // ---------------- driver: one clock cycle ----------------
   task automatic cycle(input logic s, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic fl, input logic ud,
                        input logic rn);
      logic        exp_stall;
      logic [63:0] r;
      start    = s;
      md_op    = op;
      src_a    = a;
      src_b    = b;
      flush    = fl;
      md_use_D = ud;
      reset    = rn;
      #1;
      exp_stall = ud & ((m_left > 0) | (s & ~fl & (op <= 3'd3)));
      check("stall_md", {63'd0, stall_md}, {63'd0, exp_stall});
      @(posedge clk);
      if (!rn) begin
         m_hi   = 32'd0;
         m_lo   = 32'd0;
         m_left = 0;
         exp_q.delete();
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL commit_queue got=empty exp=entry at %0t", $time);
            end else begin
               r    = exp_q.pop_front();
               m_hi = r[63:32];
               m_lo = r[31:0];
            end
         end
      end else if (s && !fl) begin
         if (op <= 3'd3) begin
            exp_q.push_back(ref_md(op, a, b));
            m_left = (op >= OP_DIV) ? N_DIV : N_MULT;
         end else if (op == OP_MTHI) begin
            m_hi = a;
         end else if (op == OP_MTLO) begin
            m_lo = a;
         end
      end
      #1;
      check("busy", {63'd0, busy}, {63'd0, (m_left > 0)});
      check("hi", {32'd0, hi}, {32'd0, m_hi});
      check("lo", {32'd0, lo}, {32'd0, m_lo});
   endtask

   task automatic idle(input int n, input logic ud);
      for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, ud, 1'b1);
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic ud);
      cycle(1'b1, op, a, b, 1'b0, ud, 1'b1);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      // Reset: everything reads zero.
      cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      check("reset_state", {63'd0, state_dbg}, 64'd0);

      // MULT -2 * 3 with D-stage HI/LO user: stall covers start + 5 busy.
      issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
      idle(N_MULT, 1'b1);
      check("mult_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
      idle(N_MULT, 1'b0);
      check("multu_lit", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

      // Division cases: sign rules, divide by zero, overflow.
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(N_DIV, 1'b0);
      check("div_lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      issue(OP_DIVU, 32'd7, 32'd0, 1'b0);
      idle(N_DIV, 1'b0);
      check("divu0_lit", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(N_DIV, 1'b0);
      check("div_ovf_lit", {hi, lo}, 64'h0000_0000_8000_0000);
      issue(OP_DIV, 32'd9, 32'd0, 1'b0);
      idle(N_DIV, 1'b0);

      // MTHI then MTLO back to back, busy never rises.
      issue(OP_MTHI, 32'h1234, 32'd0, 1'b1);
      issue(OP_MTLO, 32'h5678, 32'd0, 1'b1);
      check("mt_lit", {hi, lo}, 64'h0000_1234_0000_5678);

      // Flushed start does nothing; reserved ops do nothing.
      cycle(1'b1, OP_DIV, 32'd100, 32'd3, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, OP_MTHI, 32'hDEAD, 32'd0, 1'b1, 1'b0, 1'b1);
      issue(3'd6, 32'hAAAA, 32'd1, 1'b1);
      issue(3'd7, 32'hBBBB, 32'd1, 1'b1);

      // Starts during BUSY are dropped; the original result commits.
      issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
      issue(OP_MULT, 32'd5, 32'd5, 1'b0);
      issue(OP_MTHI, 32'hFFFF, 32'd0, 1'b0);
      issue(OP_MTLO, 32'hEEEE, 32'd0, 1'b1);
      idle(N_DIV - 3, 1'b0);
      check("busy_ignore_lit", {hi, lo}, {32'd2, 32'd14});
      // Back-to-back: new start accepted in first non-busy cycle.
      issue(OP_MULTU, 32'd6, 32'd7, 1'b0);
      idle(N_MULT, 1'b0);

      // Reset in busy cycle 3 of a DIV aborts it; nothing commits later.
      issue(OP_DIV, 32'd50, 32'd5, 1'b0);
      idle(2, 1'b0);
      cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      check("abort_lit", {hi, lo}, 64'd0);
      idle(N_DIV + 2, 1'b1);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), pick_operand(),
               pick_operand(), $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
               $urandom_range(0, 199) != 0);
      end
      idle(N_DIV + 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_hilo_md_ctrl
